// File: rtl/odd_range_pkg.sv
// Shared definitions for the odd-in-range generator / checker pair:
// default legal range, state codes and sample classification codes.
package odd_range_pkg;

    localparam int DEFAULT_DATA_W = 7;
    localparam int DEFAULT_LOW    = 34;
    localparam int DEFAULT_HIGH   = 65;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        CLS_PASS        = 2'd0,
        CLS_RANGE_FAIL  = 2'd1,
        CLS_PARITY_FAIL = 2'd2
    } class_t;

endpackage

// File: rtl/odd_range_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (inc && (value != {CNT_W{1'b1}})) begin
            value <= value + CNT_W'(1);
        end
    end

endmodule

// File: rtl/odd_range_checker.sv
// Self-check consumer for the odd-in-range generator: counts pass / range /
// parity results over a WINDOW-sample window. Optional first-failure capture
// is enabled with `define ODD_RANGE_CHECKER_FIRST_FAIL_EN.
module odd_range_checker
    import odd_range_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LOW    = DEFAULT_LOW,
    parameter int HIGH   = DEFAULT_HIGH,
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  range_fail_cnt,
    output logic [CNT_W-1:0]  parity_fail_cnt,
    output logic              busy,
    output logic              done,
    output logic              verdict
`ifdef ODD_RANGE_CHECKER_FIRST_FAIL_EN
    ,
    output logic [DATA_W-1:0] first_fail_data,
    output logic [((WINDOW > 1) ? $clog2(WINDOW) : 1)-1:0] first_fail_idx,
    output logic              first_fail_vld
`endif
);

    localparam int IDX_W = $clog2(WINDOW + 1);
    localparam logic [DATA_W-1:0] LOW_V    = DATA_W'(LOW);
    localparam logic [DATA_W-1:0] HIGH_V   = DATA_W'(HIGH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WINDOW - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last;
    class_t           cls;

    assign in_ready = (state == ST_RUN);
    assign busy     = (state == ST_RUN);
    // A start pulse takes priority over a sample presented in the same cycle.
    assign accept   = in_valid && in_ready && !start;
    assign last     = accept && (idx == LAST_IDX);

    always_comb begin
        cls = CLS_PASS;
        if ((in_data < LOW_V) || (in_data > HIGH_V)) begin
            cls = CLS_RANGE_FAIL;
        end else if (!in_data[0]) begin
            cls = CLS_PARITY_FAIL;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .inc   (accept && (cls == CLS_PASS)),
        .value (pass_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_range_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .inc   (accept && (cls == CLS_RANGE_FAIL)),
        .value (range_fail_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_parity_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .inc   (accept && (cls == CLS_PARITY_FAIL)),
        .value (parity_fail_cnt)
    );

    // The verdict folds in the final sample's class since its count lands on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            done    <= 1'b0;
            verdict <= 1'b0;
        end else if (start) begin
            state   <= ST_RUN;
            idx     <= '0;
            done    <= 1'b0;
            verdict <= 1'b0;
        end else if (accept) begin
            idx <= idx + IDX_W'(1);
            if (last) begin
                state   <= ST_DONE;
                done    <= 1'b1;
                verdict <= (range_fail_cnt == '0) && (parity_fail_cnt == '0)
                           && (cls == CLS_PASS);
            end
        end
    end

`ifdef ODD_RANGE_CHECKER_FIRST_FAIL_EN
    always_ff @(posedge clk) begin
        if (rst || start) begin
            first_fail_data <= '0;
            first_fail_idx  <= '0;
            first_fail_vld  <= 1'b0;
        end else if (accept && (cls != CLS_PASS) && !first_fail_vld) begin
            first_fail_data <= in_data;
            first_fail_idx  <= idx[$bits(first_fail_idx)-1:0];
            first_fail_vld  <= 1'b1;
        end
    end
`endif

endmodule
